// File: rtl/quad_velocity_meas_if.sv
// quad_velocity_meas_if: encoder pins, enable and
// velocity result bundle for one wheel.
interface quad_velocity_meas_if #(
  parameter int N_DATAWIDTH = 17
);
  logic                   QUAD_VELOCITY_MEAS_ENABLE_In;
  logic                   QUAD_VELOCITY_MEAS_ENC_A_In;
  logic                   QUAD_VELOCITY_MEAS_ENC_B_In;
  logic [N_DATAWIDTH-1:0] QUAD_VELOCITY_MEAS_W_OutBus;
  logic [1:0]             QUAD_VELOCITY_MEAS_DIR_OutBus;
  logic                   QUAD_VELOCITY_MEAS_VALID_Out;
  logic                   QUAD_VELOCITY_MEAS_ERROR_Out;

  modport master (
    output QUAD_VELOCITY_MEAS_ENABLE_In,
    output QUAD_VELOCITY_MEAS_ENC_A_In,
    output QUAD_VELOCITY_MEAS_ENC_B_In,
    input  QUAD_VELOCITY_MEAS_W_OutBus,
    input  QUAD_VELOCITY_MEAS_DIR_OutBus,
    input  QUAD_VELOCITY_MEAS_VALID_Out,
    input  QUAD_VELOCITY_MEAS_ERROR_Out
  );

  modport slave (
    input  QUAD_VELOCITY_MEAS_ENABLE_In,
    input  QUAD_VELOCITY_MEAS_ENC_A_In,
    input  QUAD_VELOCITY_MEAS_ENC_B_In,
    output QUAD_VELOCITY_MEAS_W_OutBus,
    output QUAD_VELOCITY_MEAS_DIR_OutBus,
    output QUAD_VELOCITY_MEAS_VALID_Out,
    output QUAD_VELOCITY_MEAS_ERROR_Out
  );
endinterface

// File: rtl/quad_velocity_meas.sv
// quad_velocity_meas: quadrature decoder with windowed
// edge count, published as signed-magnitude velocity.
module quad_velocity_meas #(
  parameter int N_DATAWIDTH   = 17,
  parameter int SAMPLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 19
) (
  input logic               QUAD_VELOCITY_MEAS_CLOCK_50,
  input logic               QUAD_VELOCITY_MEAS_RESET_InHigh,
  quad_velocity_meas_if.slave bus
);

  localparam int N = N_DATAWIDTH;
  localparam logic signed [N:0] HI =
    (N+1)'(2 ** (N-1) - 1);
  localparam logic signed [N:0] LO = -HI;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(SAMPLE_CYCLES - 1);

  logic clk;
  logic rst;
  logic en;

  assign clk = QUAD_VELOCITY_MEAS_CLOCK_50;
  assign rst = QUAD_VELOCITY_MEAS_RESET_InHigh;
  assign en  = bus.QUAD_VELOCITY_MEAS_ENABLE_In;

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev_ab;
  logic [1:0] warm;
  logic       live;

  logic inc;
  logic dec;
  logic bad;

  logic signed [N-1:0] acc;
  logic signed [N-1:0] acc_nxt;
  logic signed [N:0]   step;
  logic signed [N:0]   sum;

  logic                 neg;
  logic [N-2:0]         mag;
  logic [N-1:0]         w_nxt;
  logic [1:0]           dir_nxt;

  logic [CNT_WIDTH-1:0] cnt;
  logic [N-1:0]         w_q;
  logic [1:0]           dir_q;
  logic                 valid_q;
  logic                 err_q;

  assign live = (warm == 2'd3);

  // Two-flop synchronizer plus previous-state stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      prev_ab <= '0;
    end else begin
      sync1   <= {bus.QUAD_VELOCITY_MEAS_ENC_A_In,
                  bus.QUAD_VELOCITY_MEAS_ENC_B_In};
      sync2   <= sync1;
      prev_ab <= sync2;
    end
  end

  // Warm-up: hold off decoding until the pipe is filled
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= '0;
    end else if (!live) begin
      warm <= warm + 2'd1;
    end
  end

  // Transition decode: previous {A,B} against current
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    bad = 1'b0;
    if (live) begin
      case ({prev_ab, sync2})
        4'b0001, 4'b0111,
        4'b1110, 4'b1000: inc = 1'b1;
        4'b0100, 4'b1101,
        4'b1011, 4'b0010: dec = 1'b1;
        4'b0011, 4'b1100,
        4'b0110, 4'b1001: bad = 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating accumulate, then signed-magnitude convert
  always_comb begin
    step = '0;
    if (inc) begin
      step = (N+1)'(1);
    end else if (dec) begin
      step = '1;
    end
    sum = {acc[N-1], acc} + step;
    if (sum > HI) begin
      acc_nxt = HI[N-1:0];
    end else if (sum < LO) begin
      acc_nxt = LO[N-1:0];
    end else begin
      acc_nxt = sum[N-1:0];
    end
    neg = acc_nxt[N-1];
    if (neg) begin
      mag = (N-1)'(-acc_nxt);
    end else begin
      mag = acc_nxt[N-2:0];
    end
    w_nxt = {neg, mag};
    if (acc_nxt == '0) begin
      dir_nxt = 2'b11;
    end else if (neg) begin
      dir_nxt = 2'b10;
    end else begin
      dir_nxt = 2'b01;
    end
  end

  // Window counter, accumulator and published result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      w_q     <= '0;
      dir_q   <= 2'b11;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        cnt <= '0;
        acc <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        acc     <= '0;
        w_q     <= w_nxt;
        dir_q   <= dir_nxt;
        valid_q <= 1'b1;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
        acc <= acc_nxt;
      end
    end
  end

  // Sticky flag for transitions where both bits moved
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bad) begin
      err_q <= 1'b1;
    end
  end

  assign bus.QUAD_VELOCITY_MEAS_W_OutBus   = w_q;
  assign bus.QUAD_VELOCITY_MEAS_DIR_OutBus = dir_q;
  assign bus.QUAD_VELOCITY_MEAS_VALID_Out  = valid_q;
  assign bus.QUAD_VELOCITY_MEAS_ERROR_Out  = err_q;

endmodule

// File: tb/tb_quad_velocity_meas.sv
// tb_quad_velocity_meas: scenario tasks plus random run,
// two widths (17 and 5) fed the same encoder stimulus.
module tb_quad_velocity_meas;

  localparam int S = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_velocity_meas_if #(.N_DATAWIDTH(17)) bw();
  quad_velocity_meas_if #(.N_DATAWIDTH(5))  bn();

  quad_velocity_meas #(
    .N_DATAWIDTH(17), .SAMPLE_CYCLES(S), .CNT_WIDTH(7)
  ) dut_w (
    .QUAD_VELOCITY_MEAS_CLOCK_50(clk),
    .QUAD_VELOCITY_MEAS_RESET_InHigh(rst),
    .bus(bw)
  );

  quad_velocity_meas #(
    .N_DATAWIDTH(5), .SAMPLE_CYCLES(S), .CNT_WIDTH(7)
  ) dut_n (
    .QUAD_VELOCITY_MEAS_CLOCK_50(clk),
    .QUAD_VELOCITY_MEAS_RESET_InHigh(rst),
    .bus(bn)
  );

  int checks = 0;
  int errors = 0;
  int pos = 2;

  // reference model state
  int m_acc [2];
  int m_w   [2];
  int m_dir [2];
  int m_lim [2];
  int m_sbit[2];
  int m_cnt, m_since;
  logic m_valid, m_err;
  logic [1:0] p1, p2, p3;

  function automatic logic [1:0] gray(input int p);
    case (p % 4)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_w[k] = 0; m_dir[k] = 3;
    end
    m_cnt = 0; m_since = 0;
    m_valid = 1'b0; m_err = 1'b0;
    p1 = 2'b00; p2 = 2'b00; p3 = 2'b00;
  endtask

  // one rising edge of the model, from sampled inputs
  task automatic model_step(input logic r, input logic e,
                            input logic [1:0] ab);
    int d, st, a;
    if (r) begin
      model_reset();
      return;
    end
    if (m_since < 4) m_since++;
    d = 0;
    if (m_since >= 4) begin
      st = (gpos(p2) - gpos(p3) + 4) % 4;
      if (st == 1) d = 1;
      else if (st == 3) d = -1;
      else if (st == 2) m_err = 1'b1;
    end
    m_valid = 1'b0;
    if (e) begin
      for (int k = 0; k < 2; k++) begin
        a = m_acc[k] + d;
        if (a > m_lim[k]) a = m_lim[k];
        if (a < -m_lim[k]) a = -m_lim[k];
        if (m_cnt == S - 1) begin
          m_w[k] = (a < 0) ? (m_sbit[k] | -a) : a;
          m_dir[k] = (a == 0) ? 3 : ((a > 0) ? 1 : 2);
          m_acc[k] = 0;
        end else begin
          m_acc[k] = a;
        end
      end
      if (m_cnt == S - 1) begin
        m_valid = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      m_acc[0] = 0; m_acc[1] = 0; m_cnt = 0;
    end
    p3 = p2; p2 = p1; p1 = ab;
  endtask

  task automatic tick(input logic e, input logic r);
    logic [1:0] ab;
    ab = gray(pos);
    rst = r;
    bw.QUAD_VELOCITY_MEAS_ENABLE_In = e;
    bn.QUAD_VELOCITY_MEAS_ENABLE_In = e;
    bw.QUAD_VELOCITY_MEAS_ENC_A_In = ab[1];
    bw.QUAD_VELOCITY_MEAS_ENC_B_In = ab[0];
    bn.QUAD_VELOCITY_MEAS_ENC_A_In = ab[1];
    bn.QUAD_VELOCITY_MEAS_ENC_B_In = ab[0];
    @(posedge clk);
    model_step(r, e, ab);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  function automatic logic [29:0] obs();
    return {bw.QUAD_VELOCITY_MEAS_W_OutBus,
            bw.QUAD_VELOCITY_MEAS_DIR_OutBus,
            bw.QUAD_VELOCITY_MEAS_VALID_Out,
            bw.QUAD_VELOCITY_MEAS_ERROR_Out,
            bn.QUAD_VELOCITY_MEAS_W_OutBus,
            bn.QUAD_VELOCITY_MEAS_DIR_OutBus,
            bn.QUAD_VELOCITY_MEAS_VALID_Out,
            bn.QUAD_VELOCITY_MEAS_ERROR_Out};
  endfunction

  function automatic logic [29:0] expv();
    return {17'(m_w[0]), 2'(m_dir[0]), m_valid, m_err,
            5'(m_w[1]), 2'(m_dir[1]), m_valid, m_err};
  endfunction

  task automatic test_reset();
    logic [29:0] o, x;
    pos = 2;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, i < 5);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL reset i=%0d got %h want %h", i, o, x);
      end
    end
    checks++;
    if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h0 ||
        bw.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b11 ||
        bw.QUAD_VELOCITY_MEAS_VALID_Out !== 1'b0 ||
        bw.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h want W=0 DIR=3 V=0 E=0",
               obs());
    end
  endtask

  task automatic test_forward();
    logic [29:0] o, x;
    idle(4);
    for (int i = 0; i < 102; i++) begin
      if (i >= 2 && i <= 80 && i % 2 == 0) pos = pos + 1;
      tick(1'b1, 1'b0);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL fwd i=%0d got %h want %h", i, o, x);
      end
      if (i == 99) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h00028 ||
            bw.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b01 ||
            bw.QUAD_VELOCITY_MEAS_VALID_Out !== 1'b1 ||
            bn.QUAD_VELOCITY_MEAS_W_OutBus !== 5'b01111 ||
            bn.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b01) begin
          errors++;
          $display("FAIL fwd_result got %h want W=00028/0f DIR=1",
                   o);
        end
      end
    end
  endtask

  task automatic test_reverse();
    logic [29:0] o, x;
    idle(4);
    for (int i = 0; i < 200; i++) begin
      if (i >= 3 && i <= 75 && i % 3 == 0) pos = pos + 3;
      tick(1'b1, 1'b0);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL rev i=%0d got %h want %h", i, o, x);
      end
      if (i == 99) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h10019 ||
            bw.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b10 ||
            bn.QUAD_VELOCITY_MEAS_W_OutBus !== 5'b11111 ||
            bn.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b10) begin
          errors++;
          $display("FAIL rev_result got %h want W=10019/1f DIR=2",
                   o);
        end
      end
      if (i == 199) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h0 ||
            bw.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b11 ||
            bw.QUAD_VELOCITY_MEAS_VALID_Out !== 1'b1) begin
          errors++;
          $display("FAIL rev_empty got %h want W=0 DIR=3 V=1", o);
        end
      end
    end
  endtask

  task automatic test_boundary();
    logic [29:0] o, x;
    int w1, w2;
    w1 = -1; w2 = -1;
    idle(4);
    for (int i = 0; i < 200; i++) begin
      if ((i > 0 && i <= 50 && i % 10 == 0) || i == 97 ||
          i == 98 || i == 110 || i == 120) pos = pos + 1;
      tick(1'b1, 1'b0);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL bound i=%0d got %h want %h", i, o, x);
      end
      if (i == 99) w1 = int'(bw.QUAD_VELOCITY_MEAS_W_OutBus);
      if (i == 199) w2 = int'(bw.QUAD_VELOCITY_MEAS_W_OutBus);
    end
    checks++;
    if (w1 != 6 || w2 != 3) begin
      errors++;
      $display("FAIL bound_split got %0d+%0d want 6+3", w1, w2);
    end
    checks++;
    if (w1 + w2 != 9) begin
      errors++;
      $display("FAIL bound_total got %0d want 9", w1 + w2);
    end
  endtask

  task automatic test_error();
    logic [29:0] o, x;
    idle(4);
    checks++;
    if (bw.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b0) begin
      errors++;
      $display("FAIL err_pre got %b want 0",
               bw.QUAD_VELOCITY_MEAS_ERROR_Out);
    end
    for (int i = 0; i < 200; i++) begin
      if (i == 10 || i == 20 || i == 30 || i == 50 ||
          i == 60 || i == 70) pos = pos + 1;
      if (i == 40) pos = pos + 2;
      tick(1'b1, 1'b0);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL err i=%0d got %h want %h", i, o, x);
      end
      if (i == 99) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h6 ||
            bw.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b1) begin
          errors++;
          $display("FAIL err_count got %h want W=6 E=1", o);
        end
      end
      if (i == 199) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b1 ||
            bn.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b1) begin
          errors++;
          $display("FAIL err_sticky got %h want E=1", o);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [29:0] o, x;
    logic [16:0] held;
    logic e;
    int pulses;
    idle(4);
    held = bw.QUAD_VELOCITY_MEAS_W_OutBus;
    pulses = 0;
    for (int i = 0; i < 182; i++) begin
      if ((i > 0 && i <= 40 && i % 10 == 0) || i == 60 ||
          (i >= 90 && i <= 150 && i % 10 == 0)) pos = pos + 1;
      e = !(i >= 50 && i < 80);
      tick(e, 1'b0);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL ena i=%0d got %h want %h", i, o, x);
      end
      if (i < 179 && bw.QUAD_VELOCITY_MEAS_VALID_Out === 1'b1)
        pulses++;
      if (i == 179) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_VALID_Out !== 1'b1 ||
            bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h7) begin
          errors++;
          $display("FAIL ena_window got %h want V=1 W=7", o);
        end
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL ena_novalid got %0d pulses want 0", pulses);
    end
    checks++;
    if (held !== 17'h0) begin
      errors++;
      $display("FAIL ena_held got %h want 0", held);
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] o, x;
    idle(4);
    for (int i = 0; i < 60; i++) begin
      if (i == 10 || i == 20 || i == 30) pos = pos + 1;
      tick(1'b1, i >= 40 && i < 45);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL rstmid i=%0d got %h want %h", i, o, x);
      end
      if (i == 45) begin
        checks++;
        if (bw.QUAD_VELOCITY_MEAS_W_OutBus !== 17'h0 ||
            bw.QUAD_VELOCITY_MEAS_DIR_OutBus !== 2'b11 ||
            bw.QUAD_VELOCITY_MEAS_ERROR_Out !== 1'b0 ||
            bn.QUAD_VELOCITY_MEAS_W_OutBus !== 5'h0) begin
          errors++;
          $display("FAIL rstmid_state got %h want W=0 DIR=3 E=0",
                   o);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [29:0] o, x;
    logic e, r;
    int mv;
    int bias;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) bias = int'($urandom_range(0, 1));
      mv = int'($urandom_range(0, 127));
      if (mv < 40) pos = pos + (bias != 0 ? 1 : 3);
      else if (mv < 55) pos = pos + (bias != 0 ? 3 : 1);
      else if (mv == 56) pos = pos + 2;
      e = ($urandom_range(0, 399) != 0);
      r = ($urandom_range(0, 999) == 0);
      tick(e, r);
      o = obs(); x = expv(); checks++;
      if (o !== x) begin
        errors++;
        $display("FAIL rand i=%0d got %h want %h", i, o, x);
      end
    end
  endtask

  initial begin
    m_lim[0] = 65535; m_sbit[0] = 1 << 16;
    m_lim[1] = 15;    m_sbit[1] = 1 << 4;
    model_reset();
    rst = 1'b1;
    bw.QUAD_VELOCITY_MEAS_ENABLE_In = 1'b0;
    bn.QUAD_VELOCITY_MEAS_ENABLE_In = 1'b0;
    bw.QUAD_VELOCITY_MEAS_ENC_A_In = 1'b1;
    bw.QUAD_VELOCITY_MEAS_ENC_B_In = 1'b1;
    bn.QUAD_VELOCITY_MEAS_ENC_A_In = 1'b1;
    bn.QUAD_VELOCITY_MEAS_ENC_B_In = 1'b1;
    #1;
    test_reset();
    test_forward();
    test_reverse();
    test_boundary();
    test_error();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_velocity_meas.md
Name: quad_velocity_meas

Overview:
- Reads a wheel's quadrature encoder (channels A/B) and produces a signed-magnitude velocity word and a 2-bit direction code.
- Both outputs use the same formats the motor command path consumes:
  - velocity: MSB is the sign, the lower bits are the magnitude;
  - direction: 01 = forward, 10 = reverse, 11 = stopped.
- Sits in the feedback path between the encoder pins and the per-wheel speed controller.
- Publishes one measurement per fixed sample window.

Parameters:
N_DATAWIDTH  17  width of velocity word; bit N_DATAWIDTH-1 = sign, bits N_DATAWIDTH-2:0 = magnitude (edges per window)
SAMPLE_CYCLES  500000  clock cycles per measurement window (10 ms at 50 MHz)
CNT_WIDTH  19  width of window counter; must satisfy 2^CNT_WIDTH > SAMPLE_CYCLES

Ports:
QUAD_VELOCITY_MEAS_CLOCK_50  input  1  system clock
QUAD_VELOCITY_MEAS_RESET_InHigh  input  1  reset, synchronous, active-high
QUAD_VELOCITY_MEAS_ENABLE_In  input  1  1 = measure; 0 = hold outputs, clear window
QUAD_VELOCITY_MEAS_ENC_A_In  input  1  encoder channel A, asynchronous
QUAD_VELOCITY_MEAS_ENC_B_In  input  1  encoder channel B, asynchronous
QUAD_VELOCITY_MEAS_W_OutBus  output  N_DATAWIDTH  signed-magnitude edge count of last completed window
QUAD_VELOCITY_MEAS_DIR_OutBus  output  2  01 forward, 10 reverse, 11 stopped
QUAD_VELOCITY_MEAS_VALID_Out  output  1  one-cycle pulse when W/DIR update
QUAD_VELOCITY_MEAS_ERROR_Out  output  1  sticky illegal-transition flag

Behaviour:
- One clock. Reset is synchronous and active-high. All state registers update on the rising clock edge.
- Reset values:
  - W = 0, DIR = 11, VALID = 0, ERROR = 0.
  - Synchronizers, previous-state register, accumulator and window counter = 0.
  - Warm-up counter = 0.
- Input synchronisation and warm-up:
  - A and B each pass through 2 flops, then a previous-state register.
  - Decoding is suppressed until 3 clocks after reset release (warm-up), so no spurious edge or error is reported at start-up.
- Decode, comparing previous {A,B} to current {A,B}:
  - Forward sequence 00->01->11->10->00: +1.
  - Reverse sequence: -1.
  - No change: 0.
  - Both bits change: no count, and ERROR is set to 1 until reset.
- Latency: an encoder pin edge reaches the accumulator within 3 clocks.
- Accumulator:
  - N_DATAWIDTH-bit two's complement.
  - Saturates at +(2^(N_DATAWIDTH-1)-1) and -(2^(N_DATAWIDTH-1)-1). It never wraps.
- Window counter:
  - Counts 0..SAMPLE_CYCLES-1 while ENABLE = 1.
  - At terminal count the accumulator value, including any edge decoded in that same cycle, is captured and converted.
  - In the next cycle W and DIR show the new value and VALID = 1 for exactly that one cycle.
  - In the cycle after terminal count the accumulator restarts from 0, plus that cycle's edge, and the counter restarts from 0. No edge is lost at the window boundary.
- Conversion:
  - Sign bit = 1 if the accumulator is negative.
  - Magnitude = absolute value.
  - A zero count gives sign 0, magnitude 0, DIR = 11.
  - Nonzero count gives DIR = 01 if sign = 0, DIR = 10 if sign = 1.
  - Negative zero is never produced.
- ENABLE = 0:
  - Window counter and accumulator are held at 0. W and DIR keep their last value. VALID = 0.
  - Synchronizers and previous-state register keep tracking, so re-enabling causes no spurious count.
  - When ENABLE returns to 1, a full new window starts.
- Reset mid-window: the partial count is discarded, all reset values apply, and warm-up repeats.
- ERROR does not alter W, DIR or the counting of legal transitions.

Test Plan:
1. Reset asserted 5 cycles, encoder idle at {A,B} = 11 -> W = 0, DIR = 11, VALID = 0, ERROR = 0 after release (warm-up hides the 00->11 jump).
2. SAMPLE_CYCLES = 100, ENABLE = 1, 40 forward edges spaced 2 clocks apart inside one window -> after terminal count W = 17'h00028, DIR = 01, single VALID pulse.
3. SAMPLE_CYCLES = 100, 25 reverse edges -> W = 17'h10019, DIR = 10. Next window with no edges -> W = 0, DIR = 11, VALID pulses again.
4. One edge placed exactly on the terminal-count cycle and one on the following cycle -> the first is counted in window k, the second in window k+1. Totals across the two windows equal the total edges driven.
5. Direct jump 00->11 mid-window -> ERROR = 1 and stays 1 through later windows. Surrounding legal edges are still counted exactly.
6. N_DATAWIDTH = 5, 20 forward edges in one window -> W = 5'b01111, DIR = 01. Also: ENABLE dropped mid-window -> W holds, no VALID, new full window after re-enable. Reset mid-window -> W = 0, DIR = 11.
